sm_arbiter: RTL and testbench

Round-robin scheduler that shares one `SM` sequential multiplier among `N_REQ` requesters. Each requester submits a 16×16 operand pair over a valid/ready handshake. The block accepts one request at a time, drives the multiplier's start pulse, waits for `ready`, and returns the 32-bit product to the owning requester. It sits between the requester-side datapath and the single `SM` instance, and is the only driver of that instance's control and operand inputs.

---
 rtl/sm_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sm_arbiter.sv | 131 +++++++++++++
 tb/tb_sm_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_arb_pkg.sv
// Shared types and defaults for the SM multiplier round-robin scheduler.
// The ABORT state exists only when SM_ARB_TIMEOUT_EN is defined.
package sm_arb_pkg;

  localparam int DEF_WIDTH          = 16;
  localparam int PROD_W             = 2 * DEF_WIDTH;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_HOLD,
    S_WAIT,
`ifdef SM_ARB_TIMEOUT_EN
    S_ABORT,
`endif
    S_RESP
  } sm_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sm_arbiter.sv
// Round-robin scheduler sharing one SM sequential multiplier among N_REQ requesters.
// Define SM_ARB_TIMEOUT_EN to add the watchdog / ABORT path.
module sm_arbiter
  import sm_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = PROD_W / 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [2*WIDTH-1:0]          resp_product,
  output logic                        resp_err,
  output logic                        sm_reset,
  output logic                        sm_start,
  output logic [WIDTH-1:0]            sm_multiplicand,
  output logic [WIDTH-1:0]            sm_multiplier,
  input  logic [2*WIDTH-1:0]          sm_product,
  input  logic                        sm_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sm_arb_state_t state, state_nx;
  logic [IW-1:0]    rr_ptr, ptr_nx, owner, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             accept;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign accept = (state == S_IDLE) && !reset && (|req_valid);
  assign ptr_nx = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef SM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          err_q;

  // Counted cycles are HOLD plus each WAIT; the last one fires here.
  assign to_hit   = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign sm_reset = reset || (state == S_ABORT);
  assign resp_err = err_q;

  always_ff @(posedge clk) begin
    if (reset || state == S_LAUNCH) to_cnt <= '0;
    else if (state == S_HOLD || state == S_WAIT) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign sm_reset = reset;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    sm_start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!reset) req_ready = gnt;
        if (|req_valid) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        sm_start = !reset;
        state_nx = S_HOLD;
      end
      // sm_ready may still show the previous result here
      S_HOLD: state_nx = S_WAIT;
      S_WAIT: begin
        if (sm_ready) state_nx = S_RESP;
`ifdef SM_ARB_TIMEOUT_EN
        else if (to_hit) state_nx = S_ABORT;
`endif
      end
`ifdef SM_ARB_TIMEOUT_EN
      S_ABORT: state_nx = S_RESP;
`endif
      S_RESP: begin
        if (!reset) resp_valid[owner] = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      sm_multiplicand <= '0;
      sm_multiplier   <= '0;
      resp_product    <= '0;
`ifdef SM_ARB_TIMEOUT_EN
      err_q           <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        owner           <= gnt_idx;
        rr_ptr          <= ptr_nx;
        sm_multiplicand <= req_a[gnt_idx];
        sm_multiplier   <= req_b[gnt_idx];
      end
      if (state == S_WAIT && sm_ready) begin
        resp_product <= sm_product;
`ifdef SM_ARB_TIMEOUT_EN
        err_q        <= 1'b0;
`endif
      end
`ifdef SM_ARB_TIMEOUT_EN
      if (state == S_ABORT) begin
        resp_product <= '0;
        err_q        <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sm_arbiter.sv
// Self-checking bench for sm_arbiter: behavioural SM model, transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_sm_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 4;
  localparam int TO  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid, req_ready, resp_valid;
  logic [N-1:0][W-1:0] req_a, req_b;
  logic [2*W-1:0]      resp_product, sm_product;
  logic                resp_err, sm_reset, sm_start, sm_ready;
  logic [W-1:0]        sm_multiplicand, sm_multiplier;

  sm_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_product(resp_product), .resp_err(resp_err),
    .sm_reset(sm_reset), .sm_start(sm_start),
    .sm_multiplicand(sm_multiplicand), .sm_multiplier(sm_multiplier),
    .sm_product(sm_product), .sm_ready(sm_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // SM stand-in: ready stays high (stale) until the start is seen a cycle late.
  logic   start_d = 1'b0;
  int     sm_cnt = 0;
  bit     sm_stuck = 1'b0;
  always @(posedge clk) begin
    start_d <= sm_start;
    if (sm_reset) begin
      sm_ready <= 1'b0;
      sm_cnt   <= 0;
    end else if (start_d) begin
      sm_ready   <= 1'b0;
      sm_cnt     <= LAT;
      sm_product <= 32'(sm_multiplicand) * 32'(sm_multiplier);
    end else if (sm_cnt > 1) begin
      sm_cnt <= sm_cnt - 1;
    end else if (sm_cnt == 1) begin
      sm_cnt   <= 0;
      sm_ready <= !sm_stuck;
    end
  end

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference model: tracks cycles since accept rather than any state encoding.
  int             m_ptr = 0, m_t = 0, m_owner = 0, n_smr = 0;
  bit             m_busy = 0, m_resp = 0, m_abort = 0, m_err = 0, rst_prev = 0;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_prod;
  int             log_own[$];
  logic [2*W-1:0] log_prod[$];
  logic           log_err[$];

  initial begin
    logic [N-1:0] exp_rdy, exp_rv;
    logic         exp_start, exp_smr;
    int           g;
    forever begin
      @(negedge clk);
      exp_rdy = '0; exp_rv = '0; exp_start = 1'b0; exp_smr = reset; g = -1;
      if (!reset && !m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) exp_rdy = N'(1) << g;
      end else if (!reset) begin
        exp_start = (m_t == 1);
        if (m_resp) exp_rv = N'(1) << m_owner;
        if (m_abort) exp_smr = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("resp_valid", 64'(resp_valid), 64'(exp_rv));
      check("sm_start", 64'(sm_start), 64'(exp_start));
      check("sm_reset", 64'(sm_reset), 64'(exp_smr));
      if (!reset && m_busy) begin
        check("sm_multiplicand", 64'(sm_multiplicand), 64'(m_a));
        check("sm_multiplier", 64'(sm_multiplier), 64'(m_b));
      end
      if (!reset && m_resp) begin
        check("resp_product", 64'(resp_product), 64'(m_prod));
        check("resp_err", 64'(resp_err), 64'(m_err));
      end
      if (reset && rst_prev) begin
        check("rst_operand", 64'({sm_multiplicand, sm_multiplier}), 64'(0));
        check("rst_product", 64'(resp_product), 64'(0));
        check("rst_err", 64'(resp_err), 64'(0));
      end
      if (sm_reset && !reset) n_smr++;
      for (int i = 0; i < N; i++) if (resp_valid[i]) begin
        log_own.push_back(i);
        log_prod.push_back(resp_product);
        log_err.push_back(resp_err);
      end
      rst_prev = reset;
      if (reset) begin
        m_busy = 0; m_ptr = 0; m_resp = 0; m_abort = 0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          m_owner = g; m_a = req_a[g]; m_b = req_b[g];
          m_prod = 32'(m_a) * 32'(m_b); m_err = 0;
          m_ptr = (g + 1) % N; m_busy = 1; m_t = 1;
        end
      end else if (m_resp) begin
        m_busy = 0; m_resp = 0;
      end else if (m_abort) begin
        m_abort = 0; m_resp = 1;
      end else begin
        if (m_t >= 3 && sm_ready) m_resp = 1;
`ifdef SM_ARB_TIMEOUT_EN
        else if (m_t == TO + 1) begin m_abort = 1; m_prod = '0; m_err = 1; end
`endif
        m_t++;
      end
    end
  end

  bit [N-1:0] stream = '0;

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && !stream[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1; req_a[i] = a; req_b[i] = b;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int c = 0;
    while (log_own.size() < n && c < budget) begin tick(); c++; end
    check("resp_count", 64'(log_own.size()), 64'(n));
  endtask

  task automatic clear_log();
    log_own.delete(); log_prod.delete(); log_err.delete();
  endtask

  initial begin
    int c;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    reset = 1'b0;

    // all four at once right after reset: 0,1,2,3
    clear_log();
    for (int i = 0; i < N; i++) set_req(i, W'(i + 1), 16'd10);
    wait_resp(4, 200);
    for (int i = 0; i < 4 && i < log_own.size(); i++) begin
      check("all4_owner", 64'(log_own[i]), 64'(i));
      check("all4_prod", 64'(log_prod[i]), 64'((i + 1) * 10));
    end

    // single request on requester 0
    clear_log();
    set_req(0, 16'd3, 16'd7);
    wait_resp(1, 100);
    if (log_own.size() > 0) begin
      check("single_owner", 64'(log_own[0]), 64'(0));
      check("single_prod", 64'(log_prod[0]), 64'(21));
      check("single_err", 64'(log_err[0]), 64'(0));
    end

    // requesters 1 and 2 both keep valid high: 1,2,1,2
    clear_log();
    stream = 4'b0110;
    set_req(1, 16'd5, 16'd6);
    set_req(2, 16'd7, 16'd8);
    wait_resp(4, 300);
    stream = '0; req_valid = '0;
    for (int i = 0; i < 4 && i < log_own.size(); i++) begin
      check("alt_owner", 64'(log_own[i]), 64'((i % 2 == 0) ? 1 : 2));
      check("alt_prod", 64'(log_prod[i]), 64'((i % 2 == 0) ? 30 : 56));
    end

    // operand boundaries
    clear_log();
    set_req(3, 16'h0000, 16'h1234);
    wait_resp(1, 100);
    set_req(0, 16'hFFFF, 16'hFFFF);
    wait_resp(2, 100);
    if (log_own.size() > 1) begin
      check("zero_prod", 64'(log_prod[0]), 64'(0));
      check("max_owner", 64'(log_own[1]), 64'(0));
      check("max_prod", 64'(log_prod[1]), 64'(32'hFFFE0001));
    end

    // reset while waiting on the multiplier
    clear_log();
    set_req(1, 16'd9, 16'd9);
    c = 0;
    while (req_valid[1] && c < 20) begin tick(); c++; end
    check("rst_accept", 64'(req_valid[1]), 64'(0));
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("rst_resp_product", 64'(resp_product), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_sm_reset", 64'(sm_reset), 64'(1));
    check("rst_operands", 64'({sm_multiplicand, sm_multiplier}), 64'(0));
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("rst_no_resp", 64'(log_own.size()), 64'(0));
    set_req(3, 16'd2, 16'd3);
    set_req(0, 16'd4, 16'd5);
    wait_resp(2, 100);
    if (log_own.size() > 1) begin
      check("post_rst_first", 64'(log_own[0]), 64'(0));
      check("post_rst_prod0", 64'(log_prod[0]), 64'(20));
      check("post_rst_second", 64'(log_own[1]), 64'(3));
      check("post_rst_prod1", 64'(log_prod[1]), 64'(6));
    end

`ifdef SM_ARB_TIMEOUT_EN
    // stuck multiplier: one sm_reset pulse, then an error response
    clear_log();
    n_smr = 0;
    sm_stuck = 1'b1;
    set_req(2, 16'd5, 16'd5);
    wait_resp(1, TO + 40);
    sm_stuck = 1'b0;
    check("to_smr_pulses", 64'(n_smr), 64'(1));
    if (log_own.size() > 0) begin
      check("to_owner", 64'(log_own[0]), 64'(2));
      check("to_prod", 64'(log_prod[0]), 64'(0));
      check("to_err", 64'(log_err[0]), 64'(1));
    end
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
